// File: rtl/count_checker.sv
// count_checker
//   Checks that an 8-bit counter stream from a remote timer tile advances by
//   exactly +1 (mod 256) per sample. After LOCK_CNT consecutive +1 steps the
//   stream is declared locked. While locked, any other step raises a one-cycle
//   error pulse, bumps a saturating error counter and drops back to acquire.
//
// Parameters
//   LOCK_CNT  consecutive +1 steps needed to declare lock (1..15)
//   ERR_W     width of the error counter
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   ena        checking enable; low returns the checker to HUNT
//   cnt_in     counter stream from the transmitting tile
//   locked     high while the stream is in lock
//   err_pulse  one-cycle pulse per in-lock step error
//   err_cnt    saturating count of in-lock errors
//   last_val   most recently accepted sample
//
// Build option
//   COUNT_CHECKER_SYNC_EN  when defined, cnt_in passes through a two-stage
//                          register synchronizer (+2 cycles latency).
module count_checker #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [7:0]       cnt_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [7:0]       last_val
);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_run;
  logic [3:0]         w_run_nxt;
  logic [3:0]         w_run_inc;
  logic               r_locked;
  logic               r_err_pulse;
  logic [ERR_W-1:0]   r_err_cnt;
  logic [7:0]         r_last_val;
  logic [7:0]         w_sample;
  logic               w_match;
  logic               w_err;
  logic               w_err_sat;

`ifdef COUNT_CHECKER_SYNC_EN
  logic [7:0] r_sync1;
  logic [7:0] r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= cnt_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = r_sync2;
`else
  assign w_sample = cnt_in;
`endif

  // 8-bit addition wraps, so 0xFF -> 0x00 counts as a match.
  assign w_match   = (w_sample == (r_last_val + 8'd1));
  assign w_run_inc = r_run + 4'd1;
  assign w_err_sat = &r_err_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_err       = 1'b0;
    if (!ena) begin
      w_state_nxt = S_HUNT;
      w_run_nxt   = '0;
    end else begin
      case (r_state)
        S_HUNT: begin
          w_state_nxt = S_ACQ;
          w_run_nxt   = '0;
        end
        S_ACQ: begin
          if (w_match) begin
            w_run_nxt = w_run_inc;
            if (w_run_inc == 4'(LOCK_CNT)) begin
              w_state_nxt = S_LOCKED;
            end
          end else begin
            w_run_nxt = '0;
          end
        end
        S_LOCKED: begin
          if (!w_match) begin
            w_err       = 1'b1;
            w_run_nxt   = '0;
            w_state_nxt = S_ACQ;
          end
        end
        default: begin
          w_state_nxt = S_HUNT;
          w_run_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HUNT;
      r_run       <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
      r_last_val  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_run       <= w_run_nxt;
      // Registered from next state so locked rises on the same edge that
      // accepts the final matching sample.
      r_locked    <= (w_state_nxt == S_LOCKED);
      r_err_pulse <= w_err;
      if (w_err && !w_err_sat) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
      if (ena) begin
        r_last_val <= w_sample;
      end
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;
  assign last_val  = r_last_val;

endmodule

// File: tb/tb_count_checker.sv
module tb_count_checker;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] cnt_in;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_cnt;
  logic [7:0] last_val;

  int unsigned n_checks;
  int unsigned n_errors;

  count_checker #(
    .LOCK_CNT(4),
    .ERR_W   (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .cnt_in   (cnt_in),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_cnt  (err_cnt),
    .last_val (last_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ena;
    logic [7:0] cnt;
    logic       lk;
    logic       ep;
    logic [7:0] ec;
    logic [7:0] lv;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic [7:0] c,
                     input logic lk, input logic ep, input logic [7:0] ec,
                     input logic [7:0] lv);
    vec_t v;
    v.rst = r; v.ena = e; v.cnt = c;
    v.lk = lk; v.ep = ep; v.ec = ec; v.lv = lv;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [7:0] c);
    @(negedge clk);
    rst = r; ena = e; cnt_in = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] v;
    int unsigned exp_ec;

    rst = 1'b1; ena = 1'b0; cnt_in = 8'h00;
    n_checks = 0; n_errors = 0;

    // rst ena cnt    lk ep ec    last
    add(1, 0, 8'h55, 0, 0, 8'h00, 8'h00);  // reset state
    add(1, 1, 8'h77, 0, 0, 8'h00, 8'h00);  // rst dominates ena
    add(0, 1, 8'h10, 0, 0, 8'h00, 8'h10);  // HUNT stores
    add(0, 1, 8'h11, 0, 0, 8'h00, 8'h11);
    add(0, 1, 8'h12, 0, 0, 8'h00, 8'h12);
    add(0, 1, 8'h13, 0, 0, 8'h00, 8'h13);
    add(0, 1, 8'h14, 1, 0, 8'h00, 8'h14);  // lock on 4th match
    add(0, 1, 8'h15, 1, 0, 8'h00, 8'h15);
    add(0, 1, 8'hF9, 0, 1, 8'h01, 8'hF9);  // in-lock error
    add(0, 1, 8'hFA, 0, 0, 8'h01, 8'hFA);
    add(0, 1, 8'hFB, 0, 0, 8'h01, 8'hFB);
    add(0, 1, 8'hFC, 0, 0, 8'h01, 8'hFC);
    add(0, 1, 8'hFD, 1, 0, 8'h01, 8'hFD);
    add(0, 1, 8'hFE, 1, 0, 8'h01, 8'hFE);
    add(0, 1, 8'hFF, 1, 0, 8'h01, 8'hFF);
    add(0, 1, 8'h00, 1, 0, 8'h01, 8'h00);  // wrap is a match
    add(0, 1, 8'h01, 1, 0, 8'h01, 8'h01);
    add(0, 1, 8'h1C, 0, 1, 8'h02, 8'h1C);
    add(0, 1, 8'h1D, 0, 0, 8'h02, 8'h1D);
    add(0, 1, 8'h1E, 0, 0, 8'h02, 8'h1E);
    add(0, 1, 8'h1F, 0, 0, 8'h02, 8'h1F);
    add(0, 1, 8'h20, 1, 0, 8'h02, 8'h20);
    add(0, 1, 8'h25, 0, 1, 8'h03, 8'h25);  // jump 0x20 -> 0x25
    add(0, 1, 8'h26, 0, 0, 8'h03, 8'h26);
    add(0, 1, 8'h27, 0, 0, 8'h03, 8'h27);
    add(0, 1, 8'h28, 0, 0, 8'h03, 8'h28);
    add(0, 1, 8'h29, 1, 0, 8'h03, 8'h29);  // relock after 4 matches
    add(0, 1, 8'h2A, 1, 0, 8'h03, 8'h2A);
    add(0, 0, 8'h2B, 0, 0, 8'h03, 8'h2A);  // ena gap: held
    add(0, 0, 8'h2C, 0, 0, 8'h03, 8'h2A);
    add(0, 0, 8'h2D, 0, 0, 8'h03, 8'h2A);
    add(0, 1, 8'h40, 0, 0, 8'h03, 8'h40);  // HUNT sample
    add(0, 1, 8'h41, 0, 0, 8'h03, 8'h41);
    add(0, 1, 8'h42, 0, 0, 8'h03, 8'h42);
    add(0, 1, 8'h43, 0, 0, 8'h03, 8'h43);
    add(0, 1, 8'h44, 1, 0, 8'h03, 8'h44);
    add(0, 1, 8'h50, 0, 1, 8'h04, 8'h50);  // error
    add(0, 0, 8'h51, 0, 0, 8'h04, 8'h50);  // ena low clears pulse
    add(0, 1, 8'h60, 0, 0, 8'h04, 8'h60);
    add(0, 1, 8'h61, 0, 0, 8'h04, 8'h61);
    add(0, 1, 8'h05, 0, 0, 8'h04, 8'h05);  // ACQ mismatch: no error
    add(0, 1, 8'h06, 0, 0, 8'h04, 8'h06);
    add(0, 1, 8'h07, 0, 0, 8'h04, 8'h07);
    add(0, 1, 8'h08, 0, 0, 8'h04, 8'h08);
    add(0, 1, 8'h09, 1, 0, 8'h04, 8'h09);
    add(1, 1, 8'h0A, 0, 0, 8'h00, 8'h00);  // rst mid-lock
    add(0, 1, 8'h00, 0, 0, 8'h00, 8'h00);
    add(0, 1, 8'h01, 0, 0, 8'h00, 8'h01);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].ena, vecs[i].cnt);
      chk("locked",    i, int'(locked),    int'(vecs[i].lk));
      chk("err_pulse", i, int'(err_pulse), int'(vecs[i].ep));
      chk("err_cnt",   i, int'(err_cnt),   int'(vecs[i].ec));
      chk("last_val",  i, int'(last_val),  int'(vecs[i].lv));
    end

    // Saturation: 2^8+3 in-lock errors, relocking between each.
    step(1'b1, 1'b1, 8'h00);
    chk("sat_rst_ec", 0, int'(err_cnt), 0);
    v = 8'h00;
    step(1'b0, 1'b1, v);
    for (int k = 0; k < 4; k++) begin
      v = v + 8'd1;
      step(1'b0, 1'b1, v);
    end
    chk("sat_initial_lock", 0, int'(locked), 1);
    exp_ec = 0;
    for (int e = 0; e < 259; e++) begin
      v = v + 8'd3;
      step(1'b0, 1'b1, v);
      if (exp_ec < 255) exp_ec++;
      chk("sat_err_pulse", e, int'(err_pulse), 1);
      chk("sat_err_cnt",   e, int'(err_cnt),   int'(exp_ec));
      chk("sat_unlocked",  e, int'(locked),    0);
      for (int k = 0; k < 4; k++) begin
        v = v + 8'd1;
        step(1'b0, 1'b1, v);
        if (k == 0) chk("sat_pulse_low", e, int'(err_pulse), 0);
      end
      chk("sat_relock", e, int'(locked), 1);
    end
    chk("sat_final_ec", 0, int'(err_cnt), 255);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/count_checker.md
COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4: consecutive +1 steps needed to declare lock, range 1..15.
REQ-002 SHALL have parameter ERR_W, default 8: width of error counter.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ena  input  1  design enable, high = checking active.
REQ-006 SHALL have port cnt_in  input  8  counter stream sampled from the transmitting timer tile.
REQ-007 SHALL have port locked  output  1  high while stream is in lock.
REQ-008 SHALL have port err_pulse  output  1  one-cycle pulse per in-lock step error.
REQ-009 SHALL have port err_cnt  output  ERR_W  saturating count of in-lock errors.
REQ-010 SHALL have port last_val  output  8  most recently accepted sample.

Function
REQ-011 SHALL sample cnt_in on every rising edge with ena=1 and rst=0; the comparison path SHALL see the value after the optional synchronizer (REQ-027).
REQ-012 SHALL define a match as sample == (last_val + 1) mod 256; 0xFF -> 0x00 SHALL be a match.
REQ-013 SHALL implement a three-state FSM: HUNT, ACQ, LOCKED; reset state HUNT.
REQ-014 HUNT: first sample SHALL be stored into last_val, run counter cleared, next state ACQ; no comparison.
REQ-015 ACQ, match: run counter +1; when run counter reaches LOCK_CNT, next state LOCKED.
REQ-016 ACQ, mismatch: run counter cleared, stay ACQ, no err_pulse, err_cnt unchanged.
REQ-017 LOCKED, match: stay LOCKED, outputs unchanged except last_val.
REQ-018 LOCKED, mismatch: err_pulse=1 for exactly the following cycle, err_cnt +1 saturating at 2^ERR_W-1, run counter cleared, next state ACQ.
REQ-019 last_val SHALL update with every accepted sample in all states, match or not.
REQ-020 locked SHALL be registered and equal 1 exactly while state is LOCKED; it SHALL assert on the edge processing the LOCK_CNT-th consecutive match.
REQ-021 err_pulse SHALL be registered, latency one edge from the mismatching sample's edge, never high for two consecutive cycles unless two consecutive errors occur (impossible: second sample is in ACQ).
REQ-022 ena=0: next state SHALL be HUNT, run counter cleared, locked=0, err_pulse=0, err_cnt and last_val held.
REQ-023 err_cnt at saturation plus further errors: err_cnt SHALL hold the maximum, err_pulse SHALL still pulse.

Reset
REQ-024 rst=1 at a rising edge SHALL force: state HUNT, run counter 0, locked 0, err_pulse 0, err_cnt 0, last_val 0x00, synchronizer stages 0x00.
REQ-025 rst SHALL dominate ena and any in-progress lock or error pulse, including mid-LOCKED.
REQ-026 No output SHALL change asynchronously to clk.

Configuration
REQ-027 Macro COUNT_CHECKER_SYNC_EN: when defined, cnt_in SHALL pass through a two-stage 8-bit register synchronizer before REQ-011 sampling, adding exactly 2 cycles to every latency above; when undefined, cnt_in SHALL feed the comparison path directly with no added latency.

Verification
REQ-028 Reset released, ena=1, cnt_in 0x10,0x11,0x12,... one per cycle, LOCK_CNT=4, no sync -> locked rises after edge 5 (0x14 accepted), err_cnt=0.
REQ-029 Locked stream 0xFE,0xFF,0x00,0x01 -> locked stays 1, err_pulse never asserts.
REQ-030 Locked, cnt_in jumps 0x20 -> 0x25 -> err_pulse high one cycle, err_cnt=1, locked=0; stream continues 0x26.. -> locked again after 4 further matches.
REQ-031 Force 2^ERR_W+3 in-lock errors (relock between each) -> err_cnt=0xFF (ERR_W=8), err_pulse on every error.
REQ-032 Locked, ena=0 for 3 cycles then 1 -> locked=0 during gap, err_cnt held, relock requires 1 HUNT sample + 4 matches.
REQ-033 With COUNT_CHECKER_SYNC_EN, REQ-028 stimulus -> locked rises 2 cycles later (after edge 7); rst=1 mid-lock -> all outputs 0 next edge.
